// File: rtl/sii_l2t_req_sender.sv
// sii_l2t_req_sender: per-bank SII request packetizer toward one L2 tag bank with IQ/WIB credit flow control.
// Optional feature macro: SII_L2T_REQ_PARITY_EN adds the registered even-parity output sii_l2t_req_par.
module sii_l2t_req_sender #(
    parameter int IQ_DEPTH   = 16,
    parameter int WIB_DEPTH  = 8,
    parameter int GAP_CYCLES = 3
) (
    input  logic                               iol2clk,
    input  logic                               rst_l,
    input  logic                               desc_vld,
    output logic                               desc_rdy,
    input  logic [3:0]                         desc_opes,
    input  logic [2:0]                         desc_config,
    input  logic [13:0]                        desc_tag,
    input  logic [39:0]                        desc_addr,
    input  logic                               desc_has_data,
    input  logic [511:0]                       desc_data,
    output logic [31:0]                        sii_l2t_req,
    output logic                               sii_l2t_req_vld,
`ifdef SII_L2T_REQ_PARITY_EN
    output logic                               sii_l2t_req_par,
`endif
    input  logic                               l2t_sii_iq_dequeue,
    input  logic                               l2t_sii_wib_dequeue,
    output logic [$clog2(IQ_DEPTH+1)-1:0]      iq_credits,
    output logic [$clog2(WIB_DEPTH+1)-1:0]     wib_credits,
    output logic                               credit_err
);
    localparam int IQ_W = $clog2(IQ_DEPTH + 1);
    localparam int WIB_W = $clog2(WIB_DEPTH + 1);
    localparam logic [IQ_W-1:0] IQ_FULL = IQ_W'(IQ_DEPTH);
    localparam logic [WIB_W-1:0] WIB_FULL = WIB_W'(WIB_DEPTH);
    localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, HDR, ADDR, DATA, GAP} state_t;

    state_t       state, state_nxt;
    logic [31:0]  addr_q;
    logic         has_data_q;
    logic [511:0] data_q;
    logic [3:0]   beat;
    logic [2:0]   gap_cnt;
    logic [31:0]  req_nxt;
    logic         vld_nxt;
    logic         accept;
    logic         iq_take, wib_take, iq_sat, wib_sat, iq_ret, wib_ret;

    assign desc_rdy = (state == IDLE) && (iq_credits != '0) && (!desc_has_data || wib_credits != '0);
    assign accept   = desc_vld && desc_rdy;
    assign iq_take  = accept;
    assign wib_take = accept && desc_has_data;
    // A dequeue into an already-full counter with nothing consumed is an overflow: drop it and flag.
    assign iq_sat   = l2t_sii_iq_dequeue && !iq_take && (iq_credits == IQ_FULL);
    assign wib_sat  = l2t_sii_wib_dequeue && !wib_take && (wib_credits == WIB_FULL);
    assign iq_ret   = l2t_sii_iq_dequeue && !iq_sat;
    assign wib_ret  = l2t_sii_wib_dequeue && !wib_sat;

    // Next packet word and state; the state register names the word currently on the bus.
    always_comb begin
        state_nxt = state;
        req_nxt   = '0;
        vld_nxt   = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = accept ? HDR : IDLE;
                req_nxt   = accept ? {1'b0, desc_opes, desc_config, 2'b00, desc_tag, desc_addr[39:32]} : '0;
                vld_nxt   = accept;
            end
            HDR: begin
                state_nxt = ADDR;
                req_nxt   = addr_q;
            end
            ADDR: begin
                state_nxt = has_data_q ? DATA : GAP;
                req_nxt   = has_data_q ? data_q[31:0] : '0;
            end
            DATA: begin
                state_nxt = (beat == 4'd15) ? GAP : DATA;
                req_nxt   = (beat == 4'd15) ? '0 : data_q[{beat + 4'd1, 5'd0} +: 32];
            end
            GAP: state_nxt = (gap_cnt == GAP_LAST) ? IDLE : GAP;
            default: state_nxt = IDLE;
        endcase
    end

    // Packet FSM, registered bus outputs and descriptor capture.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state           <= IDLE;
            sii_l2t_req     <= '0;
            sii_l2t_req_vld <= 1'b0;
            addr_q          <= '0;
            has_data_q      <= 1'b0;
            data_q          <= '0;
            beat            <= '0;
            gap_cnt         <= '0;
        end else begin
            state           <= state_nxt;
            sii_l2t_req     <= req_nxt;
            sii_l2t_req_vld <= vld_nxt;
            beat            <= (state == DATA) ? beat + 4'd1 : 4'd0;
            gap_cnt         <= (state == GAP) ? gap_cnt + 3'd1 : 3'd0;
            if (accept) begin
                addr_q     <= desc_addr[31:0];
                has_data_q <= desc_has_data;
                data_q     <= desc_data;
            end
        end
    end

    // Credit counters: consume on accept, return on dequeue, saturate at depth with a sticky error.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            iq_credits  <= IQ_FULL;
            wib_credits <= WIB_FULL;
            credit_err  <= 1'b0;
        end else begin
            iq_credits  <= iq_credits - IQ_W'(iq_take) + IQ_W'(iq_ret);
            wib_credits <= wib_credits - WIB_W'(wib_take) + WIB_W'(wib_ret);
            credit_err  <= credit_err | iq_sat | wib_sat;
        end
    end

`ifdef SII_L2T_REQ_PARITY_EN
    // Even parity of the next bus word, so it lines up with sii_l2t_req; idle words are zero so parity is zero.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) sii_l2t_req_par <= 1'b0;
        else sii_l2t_req_par <= ^req_nxt;
    end
`endif
endmodule

// File: tb/tb_sii_l2t_req_sender.sv
// tb_sii_l2t_req_sender: directed self-checking bench for the SII-to-L2T request packetizer.
module tb_sii_l2t_req_sender;
    logic         iol2clk = 1'b0;
    logic         rst_l = 1'b0;
    logic         desc_vld = 1'b0;
    logic         desc_rdy;
    logic [3:0]   desc_opes = '0;
    logic [2:0]   desc_config = '0;
    logic [13:0]  desc_tag = '0;
    logic [39:0]  desc_addr = '0;
    logic         desc_has_data = 1'b0;
    logic [511:0] desc_data = '0;
    logic [31:0]  sii_l2t_req;
    logic         sii_l2t_req_vld;
    logic         sii_l2t_req_par;
    logic         l2t_sii_iq_dequeue = 1'b0;
    logic         l2t_sii_wib_dequeue = 1'b0;
    logic [4:0]   iq_credits;
    logic [3:0]   wib_credits;
    logic         credit_err;
    int           n_cmp = 0;
    int           n_bad = 0;

    sii_l2t_req_sender dut (
        .iol2clk(iol2clk),
        .rst_l(rst_l),
        .desc_vld(desc_vld),
        .desc_rdy(desc_rdy),
        .desc_opes(desc_opes),
        .desc_config(desc_config),
        .desc_tag(desc_tag),
        .desc_addr(desc_addr),
        .desc_has_data(desc_has_data),
        .desc_data(desc_data),
        .sii_l2t_req(sii_l2t_req),
        .sii_l2t_req_vld(sii_l2t_req_vld),
`ifdef SII_L2T_REQ_PARITY_EN
        .sii_l2t_req_par(sii_l2t_req_par),
`endif
        .l2t_sii_iq_dequeue(l2t_sii_iq_dequeue),
        .l2t_sii_wib_dequeue(l2t_sii_wib_dequeue),
        .iq_credits(iq_credits),
        .wib_credits(wib_credits),
        .credit_err(credit_err)
    );

`ifndef SII_L2T_REQ_PARITY_EN
    assign sii_l2t_req_par = 1'b0;
`endif

    always #5 iol2clk = ~iol2clk;

    task automatic set_desc(input logic [3:0] o, input logic [2:0] c, input logic [13:0] t,
                            input logic [39:0] a, input logic hd);
        desc_opes = o;
        desc_config = c;
        desc_tag = t;
        desc_addr = a;
        desc_has_data = hd;
    endtask

    task automatic load_wri_data();
        for (int n = 0; n < 16; n++) desc_data[32*n +: 32] = 32'hA000_0000 + 32'(n);
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (2) @(negedge iol2clk);
        n_cmp++;
        if (sii_l2t_req !== 32'h0 || sii_l2t_req_vld !== 1'b0 || sii_l2t_req_par !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_bus: req=%h vld=%b par=%b required 00000000/0/0", sii_l2t_req, sii_l2t_req_vld, sii_l2t_req_par);
        end
        n_cmp++;
        if (iq_credits !== 5'd16 || wib_credits !== 4'd8 || credit_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_credits: iq=%0d wib=%0d err=%b required 16/8/0", iq_credits, wib_credits, credit_err);
        end
        n_cmp++;
        if (desc_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_rdy: desc_rdy=%b required 1", desc_rdy);
        end
        rst_l = 1'b1;
        @(negedge iol2clk);
    endtask

    task automatic test_read();
        set_desc(4'h1, 3'h0, 14'h0005, 40'h12_3456_7890, 1'b0);
        desc_vld = 1'b1;
        n_cmp++;
        if (desc_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL read_rdy: desc_rdy=%b required 1", desc_rdy);
        end
        @(negedge iol2clk);
        desc_vld = 1'b0;
        n_cmp++;
        if (sii_l2t_req !== 32'h0800_0512 || sii_l2t_req_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL read_hdr: req=%h vld=%b required 08000512/1", sii_l2t_req, sii_l2t_req_vld);
        end
        n_cmp++;
        if (iq_credits !== 5'd15 || wib_credits !== 4'd8) begin
            n_bad++;
            $display("FAIL read_credits: iq=%0d wib=%0d required 15/8", iq_credits, wib_credits);
        end
        @(negedge iol2clk);
        n_cmp++;
        if (sii_l2t_req !== 32'h3456_7890 || sii_l2t_req_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL read_addr: req=%h vld=%b required 34567890/0", sii_l2t_req, sii_l2t_req_vld);
        end
        for (int g = 0; g < 3; g++) begin
            @(negedge iol2clk);
            n_cmp++;
            if (sii_l2t_req !== 32'h0 || sii_l2t_req_vld !== 1'b0 || desc_rdy !== 1'b0) begin
                n_bad++;
                $display("FAIL read_gap%0d: req=%h vld=%b rdy=%b required 00000000/0/0", g, sii_l2t_req, sii_l2t_req_vld, desc_rdy);
            end
        end
        @(negedge iol2clk);
        n_cmp++;
        if (desc_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL read_idle_rdy: desc_rdy=%b required 1", desc_rdy);
        end
    endtask

    task automatic test_wri();
        int k;
        load_wri_data();
        set_desc(4'h2, 3'h1, 14'h0100, 40'h00_0000_1000, 1'b1);
        desc_vld = 1'b1;
        @(negedge iol2clk);
        n_cmp++;
        if (sii_l2t_req !== 32'h1101_0000 || sii_l2t_req_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL wri_hdr: req=%h vld=%b required 11010000/1", sii_l2t_req, sii_l2t_req_vld);
        end
        n_cmp++;
        if (wib_credits !== 4'd7 || iq_credits !== 5'd14) begin
            n_bad++;
            $display("FAIL wri_credits: iq=%0d wib=%0d required 14/7", iq_credits, wib_credits);
        end
        set_desc(4'h1, 3'h0, 14'h0006, 40'h00_0000_0040, 1'b0);
        @(negedge iol2clk);
        n_cmp++;
        if (sii_l2t_req !== 32'h0000_1000 || sii_l2t_req_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL wri_addr: req=%h vld=%b required 00001000/0", sii_l2t_req, sii_l2t_req_vld);
        end
        for (int n = 0; n < 16; n++) begin
            @(negedge iol2clk);
            n_cmp++;
            if (sii_l2t_req !== 32'hA000_0000 + 32'(n) || sii_l2t_req_vld !== 1'b0) begin
                n_bad++;
                $display("FAIL wri_beat%0d: req=%h vld=%b required %h/0", n, sii_l2t_req, sii_l2t_req_vld, 32'hA000_0000 + 32'(n));
            end
        end
        k = 17;
        while (k < 40) begin
            @(negedge iol2clk);
            k++;
            if (sii_l2t_req_vld) break;
        end
        desc_vld = 1'b0;
        n_cmp++;
        if (k !== 22) begin
            n_bad++;
            $display("FAIL wri_hdr_spacing: next header after %0d cycles, required 22", k);
        end
        repeat (6) @(negedge iol2clk);
        n_cmp++;
        if (iq_credits !== 5'd13 || wib_credits !== 4'd7 || desc_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL wri_after: iq=%0d wib=%0d rdy=%b required 13/7/1", iq_credits, wib_credits, desc_rdy);
        end
    endtask

    task automatic test_returns();
        l2t_sii_iq_dequeue = 1'b1;
        l2t_sii_wib_dequeue = 1'b1;
        @(negedge iol2clk);
        l2t_sii_wib_dequeue = 1'b0;
        repeat (2) @(negedge iol2clk);
        l2t_sii_iq_dequeue = 1'b0;
        n_cmp++;
        if (iq_credits !== 5'd16 || wib_credits !== 4'd8 || credit_err !== 1'b0) begin
            n_bad++;
            $display("FAIL returns: iq=%0d wib=%0d err=%b required 16/8/0", iq_credits, wib_credits, credit_err);
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        set_desc(4'h3, 3'h2, 14'h0011, 40'h00_0000_0080, 1'b0);
        desc_vld = 1'b1;
        for (int c = 0; c < 200 && acc < 16; c++) begin
            if (desc_rdy) acc++;
            @(negedge iol2clk);
        end
        n_cmp++;
        if (acc !== 16) begin
            n_bad++;
            $display("FAIL b2b_accepts: accepted %0d, required 16", acc);
        end
        repeat (8) @(negedge iol2clk);
        n_cmp++;
        if (iq_credits !== 5'd0 || desc_rdy !== 1'b0 || sii_l2t_req_vld !== 1'b0 || sii_l2t_req !== 32'h0) begin
            n_bad++;
            $display("FAIL b2b_stall: iq=%0d rdy=%b vld=%b req=%h required 0/0/0/00000000", iq_credits, desc_rdy, sii_l2t_req_vld, sii_l2t_req);
        end
        l2t_sii_iq_dequeue = 1'b1;
        @(negedge iol2clk);
        l2t_sii_iq_dequeue = 1'b0;
        n_cmp++;
        if (iq_credits !== 5'd1 || desc_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_return: iq=%0d rdy=%b required 1/1", iq_credits, desc_rdy);
        end
        @(negedge iol2clk);
        desc_vld = 1'b0;
        n_cmp++;
        if (sii_l2t_req_vld !== 1'b1 || iq_credits !== 5'd0 || sii_l2t_req !== 32'h1A00_1100) begin
            n_bad++;
            $display("FAIL b2b_17th: vld=%b iq=%0d req=%h required 1/0/1a001100", sii_l2t_req_vld, iq_credits, sii_l2t_req);
        end
    endtask

    task automatic test_dequeue_same_cycle();
        repeat (6) @(negedge iol2clk);
        l2t_sii_iq_dequeue = 1'b1;
        repeat (4) @(negedge iol2clk);
        l2t_sii_iq_dequeue = 1'b0;
        n_cmp++;
        if (iq_credits !== 5'd4 || desc_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL same_setup: iq=%0d rdy=%b required 4/1", iq_credits, desc_rdy);
        end
        desc_vld = 1'b1;
        l2t_sii_iq_dequeue = 1'b1;
        @(negedge iol2clk);
        desc_vld = 1'b0;
        l2t_sii_iq_dequeue = 1'b0;
        n_cmp++;
        if (iq_credits !== 5'd4 || sii_l2t_req_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL same_cycle: iq=%0d vld=%b required 4/1", iq_credits, sii_l2t_req_vld);
        end
    endtask

    task automatic test_credit_err();
        repeat (6) @(negedge iol2clk);
        n_cmp++;
        if (credit_err !== 1'b0 || wib_credits !== 4'd8) begin
            n_bad++;
            $display("FAIL err_pre: err=%b wib=%0d required 0/8", credit_err, wib_credits);
        end
        l2t_sii_wib_dequeue = 1'b1;
        @(negedge iol2clk);
        l2t_sii_wib_dequeue = 1'b0;
        n_cmp++;
        if (credit_err !== 1'b1 || wib_credits !== 4'd8) begin
            n_bad++;
            $display("FAIL err_set: err=%b wib=%0d required 1/8", credit_err, wib_credits);
        end
        repeat (5) @(negedge iol2clk);
        n_cmp++;
        if (credit_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: err=%b required 1", credit_err);
        end
    endtask

    task automatic test_reset_mid_packet();
        load_wri_data();
        set_desc(4'h4, 3'h0, 14'h0002, 40'h00_0000_2000, 1'b1);
        desc_vld = 1'b1;
        @(negedge iol2clk);
        desc_vld = 1'b0;
        repeat (9) @(negedge iol2clk);
        n_cmp++;
        if (sii_l2t_req !== 32'hA000_0007) begin
            n_bad++;
            $display("FAIL abort_beat7: req=%h required a0000007", sii_l2t_req);
        end
        rst_l = 1'b0;
        #1;
        n_cmp++;
        if (sii_l2t_req !== 32'h0 || sii_l2t_req_vld !== 1'b0 || sii_l2t_req_par !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_bus: req=%h vld=%b par=%b required 00000000/0/0", sii_l2t_req, sii_l2t_req_vld, sii_l2t_req_par);
        end
        n_cmp++;
        if (iq_credits !== 5'd16 || wib_credits !== 4'd8 || credit_err !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_credits: iq=%0d wib=%0d err=%b required 16/8/0", iq_credits, wib_credits, credit_err);
        end
        @(negedge iol2clk);
        rst_l = 1'b1;
        @(negedge iol2clk);
        set_desc(4'hA, 3'h5, 14'h3FFF, 40'hFE_DEAD_BEEF, 1'b0);
        desc_vld = 1'b1;
        @(negedge iol2clk);
        desc_vld = 1'b0;
        n_cmp++;
        if (sii_l2t_req !== 32'h553F_FFFE || sii_l2t_req_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL post_hdr: req=%h vld=%b required 553ffffe/1", sii_l2t_req, sii_l2t_req_vld);
        end
`ifdef SII_L2T_REQ_PARITY_EN
        n_cmp++;
        if (sii_l2t_req_par !== 1'b1) begin
            n_bad++;
            $display("FAIL post_hdr_par: par=%b required 1", sii_l2t_req_par);
        end
`endif
        @(negedge iol2clk);
        n_cmp++;
        if (sii_l2t_req !== 32'hDEAD_BEEF || sii_l2t_req_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL post_addr: req=%h vld=%b required deadbeef/0", sii_l2t_req, sii_l2t_req_vld);
        end
`ifdef SII_L2T_REQ_PARITY_EN
        n_cmp++;
        if (sii_l2t_req_par !== 1'b0) begin
            n_bad++;
            $display("FAIL post_addr_par: par=%b required 0", sii_l2t_req_par);
        end
`endif
        @(negedge iol2clk);
        n_cmp++;
        if (sii_l2t_req !== 32'h0 || iq_credits !== 5'd15 || sii_l2t_req_par !== 1'b0) begin
            n_bad++;
            $display("FAIL post_gap: req=%h iq=%0d par=%b required 00000000/15/0", sii_l2t_req, iq_credits, sii_l2t_req_par);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_wri();
        test_returns();
        test_back_to_back();
        test_dequeue_same_cycle();
        test_credit_err();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sii_l2t_req_sender.md
Name: sii_l2t_req_sender

Overview:
- Per-bank SII-side packetizer that produces the inbound request stream toward one L2 tag bank, i.e. the `sii_l2tN_req` / `sii_l2tN_req_vld` pair.
- Accepts one request descriptor at a time and serializes it into header, address, optional 64-byte data and gap cycles.
- Enforces credit-based flow control against the bank's input queue (IQ) and I/O write buffer (WIB) using the bank's dequeue strobes.
- Instantiated 8x in SII, one per L2T bank.

Parameters:
- IQ_DEPTH, 16, IQ credits available to SII after reset.
- WIB_DEPTH, 8, WIB credits available after reset; consumed only by data-carrying (WRI) packets.
- GAP_CYCLES, 3, idle cycles forced after the last packet cycle before the next header; legal range 1..7.

Ports:
- iol2clk  in  1  I/O-L2 clock; all state updates on rising edge.
- rst_l  in  1  asynchronous active-low reset.
- desc_vld  in  1  descriptor valid.
- desc_rdy  out  1  descriptor accepted when desc_vld && desc_rdy.
- desc_opes  in  4  opcode/attribute field.
- desc_config  in  3  config field.
- desc_tag  in  14  request tag.
- desc_addr  in  40  physical address.
- desc_has_data  in  1  1 = WRI carrying 64 B.
- desc_data  in  512  write data; word 0 = bits [31:0], sent first.
- sii_l2t_req  out  32  packet bus.
- sii_l2t_req_vld  out  1  high only in the header cycle.
- l2t_sii_iq_dequeue  in  1  returns one IQ credit.
- l2t_sii_wib_dequeue  in  1  returns one WIB credit.
- iq_credits  out  $clog2(IQ_DEPTH+1)  current IQ credit count.
- wib_credits  out  $clog2(WIB_DEPTH+1)  current WIB credit count.
- credit_err  out  1  sticky overflow error flag.

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE; req=0; req_vld=0; iq_credits=IQ_DEPTH; wib_credits=WIB_DEPTH; credit_err=0; data and beat registers cleared.
  - Reset mid-packet aborts the packet immediately. The partial packet is not resumed.
- desc_rdy = (state==IDLE) && iq_credits!=0 && (!desc_has_data || wib_credits!=0).
  - desc_rdy is combinational on desc_has_data. Its other inputs are registered.
- On accept:
  - Capture the full descriptor.
  - Decrement iq_credits, and wib_credits if has_data.
  - Go to HDR.
- HDR is the first packet cycle, one cycle after accept:
  - req_vld=1.
  - req = {1'b0, opes[3:0], config[2:0], 2'b00, tag[13:0], addr[39:32]}, i.e. opes at [30:27], config at [26:24], tag at [21:8], addr[39:32] at [7:0].
  - Next state ADDR.
- ADDR: req = addr[31:0]; req_vld=0. Next state DATA if has_data, else GAP.
- DATA: 16 beats; beat n drives desc_data[32n+31:32n]; 4-bit beat counter; after beat 15 go to GAP.
- GAP: req=0 for GAP_CYCLES cycles, then IDLE.
  - Minimum header-to-header spacing: 2+GAP_CYCLES+1 cycles for reads, 18+GAP_CYCLES+1 for WRI (includes the IDLE accept cycle).
- req is driven to 0 in IDLE and GAP. All outputs except desc_rdy are registered.
- Credit counter update per cycle: next = cur − consume + return.
  - Simultaneous consume and return leaves the count unchanged.
- Dequeue while the counter already equals its DEPTH and no consume occurs in that cycle:
  - Counter saturates at DEPTH.
  - credit_err sets and stays set until reset.
- Dequeue strobes are honoured in every state, including mid-packet.
- Zero credits: desc_rdy=0, state stays IDLE, no output activity.

Optional Feature:
- Macro SII_L2T_REQ_PARITY_EN.
- When defined:
  - Adds output sii_l2t_req_par (1 bit), registered and aligned with sii_l2t_req.
  - Equals even parity (^sii_l2t_req) in HDR, ADDR and DATA cycles; 0 in IDLE and GAP; reset value 0.
- When undefined: port absent, no parity logic.

Test Plan:
- Reset release, then read desc (opes=4'h1, config=3'h0, tag=14'h0005, addr=40'h12_3456_7890, has_data=0):
  - accept+1: req_vld=1, req=32'h0800_0512.
  - accept+2: req=32'h3456_7890, req_vld=0.
  - Next 3 cycles: req=0. iq_credits=15.
- WRI desc (has_data=1, data word n = 32'hA000_0000+n):
  - 16 data beats A000_0000..A000_000F follow the address cycle.
  - wib_credits 8→7; no second header earlier than 22 cycles after the first.
- Back-to-back 16 reads, no dequeue:
  - 16 accepted; desc_rdy stays 0 on the 17th.
  - One l2t_sii_iq_dequeue pulse: 17th accepted in the next IDLE cycle.
- Dequeue on the same cycle as an accept with iq_credits=4: iq_credits remains 4.
- l2t_sii_wib_dequeue pulse with wib_credits=8 and idle: wib_credits stays 8, credit_err=1 and stays 1 until rst_l low.
- rst_l asserted during DATA beat 7: outputs 0 immediately; after release, credits back to 16/8 and a new read packet is sent correctly.
  - With SII_L2T_REQ_PARITY_EN: sii_l2t_req_par matches ^sii_l2t_req on every packet cycle.
